sopc_2_irq_aggregator: RTL and testbench
========================================

# sopc_2_irq_aggregator

Interrupt aggregation stage directly downstream of the system-clock timer and the other SOPC peripherals. It takes up to 16 raw interrupt lines, including the timer's level `irq`. For each line it synchronises, edge- or level-qualifies, latches and masks the request. It then presents one combined interrupt and a lowest-index-wins active ID to the processor through a 16-bit Avalon-MM slave with the same register access style as the timer.

## Interface
- `NUM_IRQ`, default 8: number of input lines, 1..16; unused register bits read 0.
- `clk`  in  1: system clock; everything is in this one domain.
- `reset`  in  1: synchronous, active-high; sampled on `clk` rising edge.
- `chipselect`  in  1: slave select.
- `address`  in  3: register word index.
- `write_n`  in  1: active-low write strobe; writes need `chipselect`=1.
- `writedata`  in  16: write data.
- `readdata`  out  16: registered read data.
- `irq_in`  in  NUM_IRQ: raw requests, may be asynchronous; bit 0 is the timer.
- `irq_out`  out  1: registered combined interrupt to the CPU.

## Operation
- Registers by `address`:
  - 0 PENDING: R; write-1-to-clear.
  - 1 ENABLE: R/W.
  - 2 MODE: R/W; bit=1 edge, 0 level.
  - 3 ACTIVE: R; bit15 valid, bits3:0 id; writes ignored.
  - 4 RAW: R; synchronised `irq_in`.
  - 5 FORCE: W; write-1-to-set PENDING, reads 0.
  - 6–7: read 0, writes ignored.
- Input path:
  - Two-flop synchroniser per line (`s1`, `s2`).
  - Third flop `s3` holds the previous `s2` for edge detection.
- Edge mode, bit i:
  - set = `s2[i] & ~s3[i]`, or FORCE write bit i.
  - clear = PENDING W1C bit i.
  - Set and clear in the same cycle: set wins, bit stays 1.
- Level mode, bit i:
  - PENDING[i] follows `s2[i]` OR'd with a FORCE-latched bit.
  - W1C clears only the force-latched bit.
  - Rationale: a level source (the timer) must be cleared at the source.
- Changing MODE of a bit from edge to level discards that bit's edge-latched state.
- ENABLE masks the output and the ACTIVE calculation only. Disabled lines still latch into PENDING.
- ACTIVE: lowest index i with PENDING[i] & ENABLE[i]; valid=0 and id=0 if none.
- `irq_out` <= |(PENDING & ENABLE), registered.
- Reads: `readdata` <= mux(`address`) every cycle, same as the timer; `chipselect` does not gate reads.

## Timing
- Reset values, next edge with `reset`=1:
  - `readdata` = 0, `irq_out` = 0.
  - PENDING, ENABLE, MODE, force latches, `s1`/`s2`/`s3` = 0.
  - MODE=0, so every line starts in level mode.
- `reset` asserted mid-operation clears all state at that edge; pending interrupts are lost.
- Rising `irq_in[i]` sampled at edge E:
  - `s2` high at E+1.
  - PENDING high at E+2.
  - `irq_out` high at E+3, if enabled.
- Register write at edge W:
  - Takes effect at W.
  - `irq_out` reflects the change at W+1.
  - `readdata` shows the new value at W+1 when the address is held.
- Read latency: `readdata` valid one clock after `address` is presented.
- Edge pulses shorter than one `clk` period may be missed. Sources must hold requests ≥2 cycles.
- A rising edge that repeats while PENDING is already 1 collapses into one pending; there is no counting.

## Test plan
- Reset then idle: `readdata`=0 at all addresses 0–5, `irq_out`=0 for 20 cycles.
- Edge latch:
  - MODE=0x0002, ENABLE=0x0002, pulse `irq_in[1]` high 3 cycles.
  - Expect PENDING=0x0002, ACTIVE=0x8001, `irq_out`=1 exactly 3 clocks after the rise.
  - W1C 0x0002: PENDING=0, `irq_out`=0 one clock later.
- Level timer:
  - MODE=0, ENABLE=0x0001, hold `irq_in[0]`=1.
  - W1C 0x0001: PENDING stays 0x0001.
  - Drop `irq_in[0]`: PENDING=0 two clocks later, `irq_out`=0 one clock after that.
- Priority and mask:
  - FORCE 0x0050, ENABLE=0x0040: ACTIVE=0x8006.
  - ENABLE=0x0050: ACTIVE=0x8004.
  - ENABLE=0: ACTIVE=0x0000, `irq_out`=0, PENDING still 0x0050.
- Set/clear collision: in edge mode, a new rising edge on bit 3 whose PENDING set lands in the same cycle as a W1C of bit 3 leaves PENDING[3]=1.
- Reset mid-operation: with PENDING=0x00FF and `irq_out`=1, assert `reset` for one cycle. Next edge: all registers 0, `irq_out`=0.

Source files
------------

// File: rtl/sopc_2_irq_aggregator_if.sv
// Avalon-MM slave bus for the interrupt aggregator: 16-bit data,
// eight word addresses, active-low write strobe, registered read data.
interface sopc_2_irq_aggregator_if;
    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output chipselect,
        output address,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  address,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/sopc_2_irq_aggregator.sv
// Interrupt aggregator: synchronises up to 16 raw request lines, qualifies
// each as edge or level, latches into PENDING, masks with ENABLE and
// presents a combined irq_out plus a lowest-index-wins ACTIVE id.
module sopc_2_irq_aggregator #(
    parameter int NUM_IRQ = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    sopc_2_irq_aggregator_if.slave bus,
    input  logic [NUM_IRQ-1:0]   irq_in,
    output logic                 irq_out
);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_ENABLE  = 3'd1;
    localparam logic [2:0] ADDR_MODE    = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
    localparam logic [2:0] ADDR_RAW     = 3'd4;

    // synchroniser chain; s3 is the previous s2 for edge detection
    logic [NUM_IRQ-1:0] s1_reg, s2_reg, s3_reg;

    // software-visible state
    logic [NUM_IRQ-1:0] pending_reg, pending_next;
    logic [NUM_IRQ-1:0] enable_reg,  enable_next;
    logic [NUM_IRQ-1:0] mode_reg,    mode_next;
    // FORCE bits for level-mode lines; the source level is OR'd on top
    logic [NUM_IRQ-1:0] force_lat_reg, force_lat_next;

    logic [15:0] readdata_reg;
    logic        irq_out_reg;

    // write decode
    logic               wr_en;
    logic               wr_pending, wr_enable, wr_mode, wr_force;
    logic [NUM_IRQ-1:0] wdata;

    assign wr_en      = bus.chipselect & ~bus.write_n;
    assign wr_pending = wr_en && (bus.address == ADDR_PENDING);
    assign wr_enable  = wr_en && (bus.address == ADDR_ENABLE);
    assign wr_mode    = wr_en && (bus.address == ADDR_MODE);
    assign wr_force   = wr_en && (bus.address == 3'd5);
    assign wdata      = bus.writedata[NUM_IRQ-1:0];

    // data bits above NUM_IRQ have no backing register
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    assign enable_next = wr_enable ? wdata : enable_reg;
    assign mode_next   = wr_mode   ? wdata : mode_reg;

    // Per-line pending logic. The new MODE value is used so that switching
    // a line from edge to level drops its edge-latched state immediately.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
            logic edge_set;
            logic force_bit;
            logic clr_bit;

            assign edge_set  = s2_reg[gi] & ~s3_reg[gi];
            assign force_bit = wr_force   & wdata[gi];
            assign clr_bit   = wr_pending & wdata[gi];

            // set has priority over a same-cycle write-1-to-clear
            assign force_lat_next[gi] = mode_next[gi] ? 1'b0
                                      : (force_bit | (force_lat_reg[gi] & ~clr_bit));

            assign pending_next[gi] = mode_next[gi]
                ? (edge_set | force_bit | (pending_reg[gi] & ~clr_bit))
                : (s2_reg[gi] | force_lat_next[gi]);
        end
    endgenerate

    // lowest enabled pending line wins
    logic [NUM_IRQ-1:0] masked;
    logic               active_valid;
    logic [3:0]         active_id;

    assign masked = pending_reg & enable_reg;

    // priority encoder scanning from the top so the lowest index is last to assign
    always_comb begin
        active_valid = 1'b0;
        active_id    = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (masked[i]) begin
                active_valid = 1'b1;
                active_id    = 4'(i);
            end
        end
    end

    // read mux, unconditionally registered every cycle
    logic [15:0] read_mux;

    always_comb begin
        read_mux = 16'h0000;
        case (bus.address)
            ADDR_PENDING: read_mux = 16'(pending_reg);
            ADDR_ENABLE:  read_mux = 16'(enable_reg);
            ADDR_MODE:    read_mux = 16'(mode_reg);
            ADDR_ACTIVE:  read_mux = {active_valid, 11'd0, active_id};
            ADDR_RAW:     read_mux = 16'(s2_reg);
            default:      read_mux = 16'h0000;
        endcase
    end

    // input synchroniser and edge-detect history
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg <= '0;
            s2_reg <= '0;
            s3_reg <= '0;
        end else begin
            s1_reg <= irq_in;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    // register file, pending latches and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg   <= '0;
            enable_reg    <= '0;
            mode_reg      <= '0;
            force_lat_reg <= '0;
            readdata_reg  <= 16'h0000;
            irq_out_reg   <= 1'b0;
        end else begin
            pending_reg   <= pending_next;
            enable_reg    <= enable_next;
            mode_reg      <= mode_next;
            force_lat_reg <= force_lat_next;
            readdata_reg  <= read_mux;
            irq_out_reg   <= |masked;
        end
    end

    assign bus.readdata = readdata_reg;
    assign irq_out      = irq_out_reg;

endmodule

// File: tb/tb_sopc_2_irq_aggregator.sv
// Directed bench for the interrupt aggregator. Inputs change 1 ns after a
// rising edge; outputs are sampled at the same point.
module tb_sopc_2_irq_aggregator;

    logic       clk;
    logic       reset;
    logic [7:0] irq_in;
    logic       irq_out;

    int checks;
    int errors;

    sopc_2_irq_aggregator_if bus_if();

    sopc_2_irq_aggregator #(.NUM_IRQ(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if),
        .irq_in  (irq_in),
        .irq_out (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%04h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // write sampled at the next rising edge
    task automatic bus_write(input logic [2:0] addr, input logic [15:0] data);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.address    = addr;
        bus_if.writedata  = data;
        tick();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [15:0] data);
        bus_if.address = addr;
        tick();
        data = bus_if.readdata;
    endtask

    logic [15:0] rd;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        irq_in = 8'h00;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.address    = 3'd0;
        bus_if.writedata  = 16'h0000;
        repeat (3) tick();
        check("reset_readdata", bus_if.readdata, 16'h0000);
        check("reset_irq_out", {15'd0, irq_out}, 16'h0000);
        reset = 1'b0;

        // idle: every address reads 0, no interrupt
        for (int a = 0; a < 6; a++) begin
            bus_read(3'(a), rd);
            check($sformatf("idle_addr%0d", a), rd, 16'h0000);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("idle_irq_c%0d", c), {15'd0, irq_out}, 16'h0000);
        end

        // edge latch on line 1
        bus_write(3'd2, 16'h0002);
        bus_write(3'd1, 16'h0002);
        irq_in[1] = 1'b1;          // sampled at edge E
        tick();                    // E
        tick();                    // E+1
        tick();                    // E+2
        check("edge_irq_e2", {15'd0, irq_out}, 16'h0000);
        irq_in[1] = 1'b0;
        tick();                    // E+3
        check("edge_irq_e3", {15'd0, irq_out}, 16'h0001);
        bus_read(3'd0, rd);
        check("edge_pending", rd, 16'h0002);
        bus_read(3'd3, rd);
        check("edge_active", rd, 16'h8001);
        bus_write(3'd0, 16'h0002);
        tick();
        check("edge_w1c_irq", {15'd0, irq_out}, 16'h0000);
        bus_read(3'd0, rd);
        check("edge_w1c_pending", rd, 16'h0000);

        // level timer on line 0
        bus_write(3'd2, 16'h0000);
        bus_write(3'd1, 16'h0001);
        irq_in[0] = 1'b1;
        repeat (4) tick();
        check("level_irq_on", {15'd0, irq_out}, 16'h0001);
        bus_read(3'd4, rd);
        check("level_raw", rd, 16'h0001);
        bus_write(3'd0, 16'h0001);
        repeat (2) tick();
        bus_read(3'd0, rd);
        check("level_w1c_holds", rd, 16'h0001);
        irq_in[0] = 1'b0;          // sampled at edge D
        tick();                    // D
        tick();                    // D+1
        tick();                    // D+2
        check("level_irq_d2", {15'd0, irq_out}, 16'h0001);
        tick();                    // D+3
        check("level_irq_d3", {15'd0, irq_out}, 16'h0000);
        bus_read(3'd0, rd);
        check("level_pending_drop", rd, 16'h0000);

        // priority and mask
        bus_write(3'd1, 16'h0040);
        bus_write(3'd5, 16'h0050);
        bus_read(3'd3, rd);
        check("prio_active_6", rd, 16'h8006);
        bus_write(3'd1, 16'h0050);
        bus_read(3'd3, rd);
        check("prio_active_4", rd, 16'h8004);
        bus_write(3'd1, 16'h0000);
        bus_read(3'd3, rd);
        check("prio_active_none", rd, 16'h0000);
        check("prio_irq_masked", {15'd0, irq_out}, 16'h0000);
        bus_read(3'd0, rd);
        check("prio_pending", rd, 16'h0050);
        bus_read(3'd5, rd);
        check("force_reads_0", rd, 16'h0000);
        bus_read(3'd7, rd);
        check("addr7_reads_0", rd, 16'h0000);
        bus_write(3'd1, 16'hFFFF);
        bus_read(3'd1, rd);
        check("enable_width", rd, 16'h00FF);
        bus_write(3'd0, 16'h0050);
        bus_read(3'd0, rd);
        check("force_w1c", rd, 16'h0000);

        // set/clear collision on line 3
        bus_write(3'd2, 16'h0008);
        bus_write(3'd1, 16'h0008);
        irq_in[3] = 1'b1;          // sampled at edge E
        tick();                    // E
        tick();                    // E+1
        bus_if.chipselect = 1'b1;  // W1C lands at E+2 with the set
        bus_if.write_n    = 1'b0;
        bus_if.address    = 3'd0;
        bus_if.writedata  = 16'h0008;
        tick();                    // E+2
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_read(3'd0, rd);
        check("collision_set_wins", rd, 16'h0008);
        bus_write(3'd0, 16'h0008);
        bus_read(3'd0, rd);
        check("collision_then_clear", rd, 16'h0000);
        irq_in[3] = 1'b0;

        // reset mid-operation
        bus_write(3'd2, 16'h000F);
        bus_write(3'd1, 16'h00FF);
        bus_write(3'd5, 16'h00FF);
        repeat (2) tick();
        check("rst_pre_irq", {15'd0, irq_out}, 16'h0001);
        bus_read(3'd0, rd);
        check("rst_pre_pending", rd, 16'h00FF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_irq_out", {15'd0, irq_out}, 16'h0000);
        check("rst_readdata", bus_if.readdata, 16'h0000);
        for (int a = 0; a < 5; a++) begin
            bus_read(3'(a), rd);
            check($sformatf("rst_addr%0d", a), rd, 16'h0000);
        end
        repeat (3) tick();
        check("rst_irq_idle", {15'd0, irq_out}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
